// File: rtl/ag_tcu_bhf_pkg.sv
// Shared constants and types for the BHF tensor-core return path.
package ag_tcu_bhf_pkg;

   localparam int FP32_REC_WIDTH = 33;
   localparam int FP32_WIDTH     = 32;
   localparam int BF16_WIDTH     = 16;

   localparam logic [BF16_WIDTH-1:0] BF16_QNAN = 16'h7FC0;
   localparam logic [BF16_WIDTH-1:0] BF16_PINF = 16'h7F80;

   // Bit positions inside bhf_flags_t: {nan, overflow, inexact}
   localparam int FLG_NAN = 2;
   localparam int FLG_OVF = 1;
   localparam int FLG_NX  = 0;

   typedef logic [2:0] bhf_flags_t;

endpackage

// File: rtl/ag_tcu_bhf_rec2bf16_pack_recfn_to_fn.sv
// HardFloat-style recFNToFN for expWidth 8 / sigWidth 24: 33-bit recoded
// float to standard FP32 bit pattern. Purely combinational.
module ag_tcu_bhf_rec2bf16_pack_recfn_to_fn
   import ag_tcu_bhf_pkg::*;
(
   input  logic [FP32_REC_WIDTH-1:0] rec,
   output logic [FP32_WIDTH-1:0]     fp
);

   logic        sign;
   logic [8:0]  exp_in;
   logic [22:0] fract_in;
   logic        is_zero;
   logic        is_special;
   logic        is_inf;
   logic        is_sub;
   logic [8:0]  denorm_shift;
   logic [22:0] sub_fract;
   logic [7:0]  norm_exp;
   logic [7:0]  exp_out;
   logic [22:0] fract_out;

   assign sign     = rec[32];
   assign exp_in   = rec[31:23];
   assign fract_in = rec[22:0];

   // Recoded exponent = biased FP32 exponent + 129; top three bits encode zero/inf/nan.
   assign is_zero    = (exp_in[8:6] == 3'b000);
   assign is_special = (exp_in[8:7] == 2'b11);
   assign is_inf     = is_special & ~exp_in[6];
   assign is_sub     = (exp_in < 9'd130);

   // Subnormal results: re-insert the hidden bit and shift right into the fraction field.
   assign denorm_shift = 9'd129 - exp_in;
   assign sub_fract    = {~is_zero, fract_in[22:1]} >> denorm_shift;
   assign norm_exp     = exp_in[7:0] - 8'd129;

   // Select exponent and fraction by operand class.
   always_comb begin
      exp_out   = norm_exp;
      fract_out = fract_in;
      if (is_sub) begin
         exp_out   = 8'h00;
         fract_out = sub_fract;
      end else if (is_special) begin
         exp_out = 8'hFF;
         if (is_inf) fract_out = 23'd0;
      end
   end

   assign fp = {sign, exp_out, fract_out};

endmodule

// File: rtl/ag_tcu_bhf_rec2bf16_pack.sv
// Recoded FP32 -> BF16 (RNE) converter and lane packer with valid/ready on both sides.
// S1: recoded-to-FP32 conversion register. S2: rounding and pack buffer / output beat.
// Build option AG_TCU_BHF_FTZ_EN: flush FP32 subnormals to signed zero (inexact set).
module ag_tcu_bhf_rec2bf16_pack
   import ag_tcu_bhf_pkg::*;
#(
   parameter int OUT_LANES = 2
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [FP32_REC_WIDTH-1:0]        in_data,
   input  logic                             in_last,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [BF16_WIDTH*OUT_LANES-1:0]  out_data,
   output logic [OUT_LANES-1:0]             out_mask,
   output bhf_flags_t                       out_flags
);

   localparam int               CNT_W     = (OUT_LANES > 1) ? $clog2(OUT_LANES) : 1;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(OUT_LANES - 1);

   logic                            adv;
   logic [FP32_WIDTH-1:0]           conv_fp;

   logic                            s1_valid;
   logic                            s1_last;
   logic [FP32_WIDTH-1:0]           s1_fp;

   logic [CNT_W-1:0]                pack_cnt;
   logic [BF16_WIDTH*OUT_LANES-1:0] pack_data;
   logic [OUT_LANES-1:0]            pack_mask;
   bhf_flags_t                      pack_flags;

   logic [BF16_WIDTH-1:0]           rnd_bf;
   bhf_flags_t                      rnd_flags;
   logic [BF16_WIDTH*OUT_LANES-1:0] merged_data;
   logic [OUT_LANES-1:0]            merged_mask;
   bhf_flags_t                      merged_flags;
   logic                            emit;

   // Whole pipeline freezes while a beat is held; a full beat can then never be overwritten.
   assign adv      = ~(out_valid & ~out_ready);
   assign in_ready = adv & reset_n;

   ag_tcu_bhf_rec2bf16_pack_recfn_to_fn u_recfn_to_fn (
      .rec (in_data),
      .fp  (conv_fp)
   );

   // S1: capture converted FP32 value; last is qualified so a bubble never carries it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_fp    <= '0;
      end else if (adv) begin
         s1_valid <= in_valid;
         s1_last  <= in_valid & in_last;
         s1_fp    <= conv_fp;
      end
   end

   // S2 rounding: FP32 to BF16 round-to-nearest-even with special-case handling.
   always_comb begin
      rnd_bf    = s1_fp[31:16] + {15'd0, s1_fp[15] & ((|s1_fp[14:0]) | s1_fp[16])};
      rnd_flags = '0;
      if (s1_fp[30:23] == 8'hFF) begin
         if (s1_fp[22:0] != 23'd0) begin
            rnd_bf             = BF16_QNAN;
            rnd_flags[FLG_NAN] = 1'b1;
         end else begin
            rnd_bf = {s1_fp[31], BF16_PINF[14:0]};
         end
      end
`ifdef AG_TCU_BHF_FTZ_EN
      else if ((s1_fp[30:23] == 8'h00) && (s1_fp[22:0] != 23'd0)) begin
         rnd_bf            = {s1_fp[31], 15'd0};
         rnd_flags[FLG_NX] = 1'b1;
      end
`endif
      else begin
         rnd_flags[FLG_NX]  = s1_fp[15] | (|s1_fp[14:0]);
         rnd_flags[FLG_OVF] = (rnd_bf[14:0] == BF16_PINF[14:0]);
      end
   end

   // S2 merge: drop the rounded value into the current lane and decide on emission.
   always_comb begin
      merged_data = pack_data;
      merged_data[pack_cnt*BF16_WIDTH +: BF16_WIDTH] = rnd_bf;
      merged_mask = pack_mask;
      merged_mask[pack_cnt] = 1'b1;
      merged_flags = pack_flags | rnd_flags;
      emit = s1_valid & (s1_last | (pack_cnt == LAST_LANE));
   end

   // Pack buffer: accumulate lanes until a beat is emitted, then restart at lane 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pack_cnt   <= '0;
         pack_data  <= '0;
         pack_mask  <= '0;
         pack_flags <= '0;
      end else if (adv && s1_valid) begin
         if (emit) begin
            pack_cnt   <= '0;
            pack_data  <= '0;
            pack_mask  <= '0;
            pack_flags <= '0;
         end else begin
            pack_cnt   <= pack_cnt + 1'b1;
            pack_data  <= merged_data;
            pack_mask  <= merged_mask;
            pack_flags <= merged_flags;
         end
      end
   end

   // Output beat: load on emission (also while the previous beat is being taken), else clear once consumed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_mask  <= '0;
         out_flags <= '0;
      end else if (adv) begin
         if (emit) begin
            out_valid <= 1'b1;
            out_data  <= merged_data;
            out_mask  <= merged_mask;
            out_flags <= merged_flags;
         end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mask  <= '0;
            out_flags <= '0;
         end
      end
   end

endmodule
